// File: rtl/alu_uart_interface_pkg.sv
// Purpose: shared types/constants for the UART-fed ALU control stage and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_if_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 6;

  // 3-bit state encoding; values 6 and 7 are unused and recover to S_OP_A
  typedef enum logic [2:0] {
    S_OP_A    = 3'd0,
    S_OP_B    = 3'd1,
    S_OPCODE  = 3'd2,
    S_RESULT  = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  // opcodes understood by the downstream ALU
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Purpose: bundle of receiver, ALU and transmitter signals around the control stage.
// Latency: n/a (wiring only).
// Backpressure: none; tx side is a start/done handshake, rx side a level strobe.
interface alu_uart_if
  import alu_if_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);

  logic              i_rx_done;
  logic [DATA_W-1:0] i_rx_byte;
  logic [DATA_W-1:0] i_alu_result;
  logic              i_tx_done;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [OP_W-1:0]   o_alu_op;
  logic              o_tx_start;
  logic [DATA_W-1:0] o_tx_byte;
  logic              o_busy;

  // environment side: receiver, ALU and transmitter
  modport master (
    output i_rx_done, i_rx_byte, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_byte, o_busy
  );

  // control stage side
  modport slave (
    input  i_rx_done, i_rx_byte, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_byte, o_busy
  );

endinterface

// File: rtl/alu_uart_interface_rise_detect.sv
// Purpose: turn a level receive strobe into a single-cycle byte event.
// Latency: combinational from i_level; one register of history.
// Backpressure: none; a strobe held for many cycles yields exactly one event.
module rise_detect (
  input  logic i_Clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  // remember last cycle's strobe level
  always_ff @(posedge i_Clock) begin
    if (i_reset) level_q <= 1'b0;
    else         level_q <= i_level;
  end

  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/alu_uart_interface.sv
// Purpose: assemble A, B, opcode from UART bytes, capture ALU result, request one-byte send.
// Latency: opcode event at edge E -> o_tx_start high E+1..E+2, o_tx_byte valid from E+1.
// Backpressure: bytes arriving while busy are dropped; waits on i_tx_done. Option: ALU_IF_TIMEOUT_EN.
module alu_uart_interface
  import alu_if_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int OP_W           = DEF_OP_W,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic      i_Clock,
  input logic      i_reset,
  alu_uart_if.slave bus
);

  state_t state;
  logic   rx_evt;

  rise_detect u_rise (
    .i_Clock (i_Clock),
    .i_reset (i_reset),
    .i_level (bus.i_rx_done),
    .o_rise  (rx_evt)
  );

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout;

  assign timeout = (idle_cnt == CNT_LAST);

  // idle counter only runs while a frame is partially received
  always_ff @(posedge i_Clock) begin
    if (i_reset)
      idle_cnt <= '0;
    else if (rx_evt || !(state == S_OP_B || state == S_OPCODE))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + CNT_W'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // frame sequencer with registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state          <= S_OP_A;
      bus.o_alu_a    <= '0;
      bus.o_alu_b    <= '0;
      bus.o_alu_op   <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_byte  <= '0;
      bus.o_busy     <= 1'b0;
    end else begin
      case (state)
        S_OP_A: begin
          if (rx_evt) begin
            bus.o_alu_a <= bus.i_rx_byte;
            state       <= S_OP_B;
          end
        end
        S_OP_B: begin
          if (rx_evt) begin
            bus.o_alu_b <= bus.i_rx_byte;
            state       <= S_OPCODE;
          end
`ifdef ALU_IF_TIMEOUT_EN
          else if (timeout) begin
            state <= S_OP_A;
          end
`endif
        end
        S_OPCODE: begin
          if (rx_evt) begin
            bus.o_alu_op <= bus.i_rx_byte[OP_W-1:0];
            bus.o_busy   <= 1'b1;
            state        <= S_RESULT;
          end
`ifdef ALU_IF_TIMEOUT_EN
          else if (timeout) begin
            state <= S_OP_A;
          end
`endif
        end
        S_RESULT: begin
          // ALU has had a full cycle to settle on the new opcode
          bus.o_tx_byte  <= bus.i_alu_result;
          bus.o_tx_start <= 1'b1;
          state          <= S_SEND;
        end
        S_SEND: begin
          bus.o_tx_start <= 1'b0;
          state          <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (bus.i_tx_done) begin
            bus.o_busy <= 1'b0;
            state      <= S_OP_A;
          end
        end
        default: begin
          bus.o_tx_start <= 1'b0;
          bus.o_busy     <= 1'b0;
          state          <= S_OP_A;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Control stage directly downstream of the UART receiver. It consumes received bytes (data strobe plus byte) and assembles them into operand A, operand B and an opcode that drive the combinational ALU. After the ALU settles, it captures the result and hands it to the UART transmitter as a one-byte send request, then waits for transmit completion. It runs on the same clock as the receiver, transmitter and baud generator.

## Interface
- DATA_W, 8, operand/result width; equals the UART byte width
- OP_W, 6, opcode width; taken from the low OP_W bits of the third byte
- TIMEOUT_CYCLES, 50_000_000, idle-cycle limit between bytes of one frame; used only under ALU_IF_TIMEOUT_EN

Ports:
- i_Clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_done  in  1  receiver byte-complete strobe; level, may stay high more than one cycle
- i_rx_byte  in  DATA_W  received byte; valid while i_rx_done is high
- i_alu_result  in  DATA_W  combinational ALU result
- i_tx_done  in  1  transmitter finished sending; pulse
- o_alu_a  out  DATA_W  operand A register
- o_alu_b  out  DATA_W  operand B register
- o_alu_op  out  OP_W  opcode register
- o_tx_start  out  1  one-cycle send request
- o_tx_byte  out  DATA_W  byte to transmit; held stable until the next result
- o_busy  out  1  high in S_RESULT, S_SEND and S_WAIT_TX

## Operation
- Byte event: i_rx_done sampled high at a clock edge while its registered previous value was 0. One event per strobe, regardless of strobe length.
- States:
  - S_OP_A: on event, latch o_alu_a and go to S_OP_B.
  - S_OP_B: on event, latch o_alu_b and go to S_OPCODE.
  - S_OPCODE: on event, latch o_alu_op = byte[OP_W-1:0] and go to S_RESULT.
  - S_RESULT: unconditional; latch o_tx_byte = i_alu_result, set o_tx_start = 1, go to S_SEND.
  - S_SEND: clear o_tx_start and go to S_WAIT_TX.
  - S_WAIT_TX: on i_tx_done, go to S_OP_A.
- Byte events in S_RESULT, S_SEND and S_WAIT_TX are discarded. They are not queued.
- i_tx_done outside S_WAIT_TX is ignored.
- Operand and opcode registers keep their values across frames until overwritten.
- Unused state encodings go to S_OP_A with o_tx_start = 0.

## Timing
- Reset: state S_OP_A, all outputs 0, edge-detect register 0.
- Reset has priority over every event in the same cycle. Reset mid-frame abandons partial operands; o_tx_start drops at the reset edge.
- Latency: the opcode event at edge E gives o_tx_start high exactly from E+1 to E+2, with o_tx_byte valid from E+1.
- Return to S_OP_A at the edge that samples i_tx_done high. An event at the next edge is accepted.
- An event coinciding with i_tx_done in S_WAIT_TX is discarded.

## Configuration
- ALU_IF_TIMEOUT_EN defined:
  - An inter-byte counter runs in S_OP_B and S_OPCODE and clears on each event and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 without an event, the state returns to S_OP_A. Latched registers are unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- ALU_IF_TIMEOUT_EN undefined: no counter; S_OP_B and S_OPCODE wait indefinitely.

## Structure
- Shared package alu_if_pkg holds:
  - the state localparams (3-bit encoding);
  - DATA_W and OP_W defaults;
  - the opcode constants shared with the ALU: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111.
- One sub-module, rise_detect: registers i_rx_done and outputs the single-cycle event.

## Test plan
- Strobes carrying 0x05, 0x03, 0x20 (ADD), with the ALU model giving 0x08 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_start pulses once for one cycle; o_tx_byte=0x08. After i_tx_done, o_busy=0.
- i_rx_done held high for 5 cycles with 0xAA -> only o_alu_a=0xAA is latched; state S_OP_B.
- Byte 0x77 strobed during S_WAIT_TX -> discarded. The next frame 0x01, 0x01, 0x22 (SUB) gives o_alu_a=0x01 and o_tx_byte equal to the result, 0x00.
- i_reset asserted after operand A=0x10 -> all outputs 0, state S_OP_A. The next byte 0x09 lands in o_alu_a.
- i_tx_done pulsed in S_OP_B -> no state change; o_tx_start stays 0.
- With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0x04, then idle 16 cycles -> state S_OP_A. The next byte 0x06 updates o_alu_a, not o_alu_b.
